// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter: buffers producer bytes and
// launches them one start pulse at a time, waiting for tx_finish between frames.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_finish
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic [1:0]        state_reg, state_next;
    logic              tx_start_reg, tx_start_next;
    logic [7:0]        tx_data_reg;
    logic              overflow_reg, overflow_next;
    logic              push, pop;

    assign full  = (count_reg == DEPTH_C);
    assign empty = (count_reg == '0);
    assign busy  = (state_reg != S_IDLE) || !empty;

    // full is the pre-edge value, so a push while full is dropped even if a pop
    // frees a slot on the same edge.
    assign push = wr_en && !full;
    assign pop  = (state_reg == S_IDLE) && !empty;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (wr_en && full) begin
            overflow_next = 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        tx_start_next = tx_start_reg;
        case (state_reg)
            S_IDLE: begin
                if (!empty) begin
                    tx_start_next = 1'b1;
                    state_next    = S_START;
                end
            end
            S_START: begin
                tx_start_next = 1'b0;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                if (tx_finish) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                tx_start_next = 1'b0;
                state_next    = S_IDLE;
            end
        endcase
    end

    // Storage array is never reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            state_reg    <= S_IDLE;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            state_reg    <= state_next;
            tx_start_reg <= tx_start_next;
            overflow_reg <= overflow_next;
            if (pop) begin
                tx_data_reg <= mem[rd_ptr_reg];
            end
        end
    end

    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a transmitter stub whose finish flag
// rises 20 clocks after it samples a start pulse.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full, empty, overflow, busy, tx_start;
    logic [4:0] count;
    logic [7:0] tx_data;
    logic       tx_finish;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [7:0] rx_q[$];
    int         pulse_q[$];
    logic [7:0] exp_q[$];

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .busy      (busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_finish (tx_finish)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter stub: clears finish on the sampled-start edge, sets it 20 edges later.
    logic [4:0] stub_cnt;
    logic       stub_active;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_finish   <= 1'b0;
            stub_cnt    <= 5'd0;
            stub_active <= 1'b0;
        end else if (tx_start) begin
            tx_finish   <= 1'b0;
            stub_cnt    <= 5'd19;
            stub_active <= 1'b1;
        end else if (stub_active) begin
            if (stub_cnt == 5'd0) begin
                tx_finish   <= 1'b1;
                stub_active <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 5'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            rx_q.push_back(tx_data);
            pulse_q.push_back(cyc);
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        tick();
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (busy && k < 1000) begin
            tick();
            k++;
        end
        check(tag, busy, 0);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i),
                  (i < rx_q.size()) ? 32'(rx_q[i]) : 32'bx, exp_q[i]);
        end
    endtask

    task automatic clear_logs();
        rx_q.delete();
        pulse_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tx_data", tx_data, 8'h00);
        $display("reset: full=%0b empty=%0b busy=%0b count=%0d", full, empty, busy, count);

        // Single push: count in cycle 1, start pulse in cycle 2 only.
        clear_logs();
        push_byte(8'hA5);
        wr_en = 1'b0;
        check("single_c1_count", count, 1);
        check("single_c1_empty", empty, 0);
        check("single_c1_tx_start", tx_start, 0);
        tick();
        check("single_c2_tx_start", tx_start, 1);
        check("single_c2_tx_data", tx_data, 8'hA5);
        check("single_c2_count", count, 0);
        tick();
        check("single_c3_tx_start", tx_start, 0);
        check("single_c3_busy", busy, 1);
        n = 0;
        while (!tx_finish && n < 40) begin
            tick();
            n++;
        end
        check("single_finish_seen", tx_finish, 1);
        check("single_finish_delay", n, 20);
        check("single_busy_at_finish", busy, 1);
        tick();
        check("single_busy_after_finish", busy, 0);
        check("single_pulses", pulse_q.size(), 1);
        $display("single: tx_data=0x%0h pulses=%0d", tx_data, pulse_q.size());

        // Burst of 16: in-order delivery and 23-clock pulse spacing.
        clear_logs();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        wr_en = 1'b0;
        drain("burst_drain");
        check_rx("burst");
        check("burst_pulses", pulse_q.size(), 16);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("burst_gap%0d", i),
                  (i < pulse_q.size()) ? 32'(pulse_q[i] - pulse_q[i-1]) : 32'bx, 23);
        end
        check("burst_overflow", overflow, 0);
        $display("burst: received=%0d pulses=%0d", rx_q.size(), pulse_q.size());

        // Overflow: 17 pushes with the first in flight fill the FIFO exactly.
        clear_logs();
        for (int i = 0; i < 17; i++) push_byte(8'h20 + 8'(i));
        check("ovf_count_peak", count, 16);
        check("ovf_full", full, 1);
        check("ovf_not_yet", overflow, 0);
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_count_after_drop", count, 16);
        drain("ovf_drain");
        check("ovf_sticky", overflow, 1);
        check_rx("ovf");
        $display("overflow: received=%0d overflow=%0b", rx_q.size(), overflow);

        // Reset mid-frame with 5 bytes queued.
        clear_logs();
        for (int i = 0; i < 6; i++) push_byte(8'h50 + 8'(i));
        wr_en = 1'b0;
        tick();
        check("midrst_queued", count, 5);
        rst_n = 1'b0;
        #1;
        check("midrst_full", full, 0);
        check("midrst_empty", empty, 1);
        check("midrst_busy", busy, 0);
        check("midrst_count", count, 0);
        check("midrst_tx_start", tx_start, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_tx_data", tx_data, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_stays_idle", busy, 0);
        $display("midreset: count=%0d busy=%0b overflow=%0b", count, busy, overflow);

        // Push and pop on the same edge with count=3.
        clear_logs();
        push_byte(8'h40);
        wr_en = 1'b0;
        tick();
        tick();
        for (int i = 1; i < 4; i++) push_byte(8'h40 + 8'(i));
        wr_en = 1'b0;
        n = 0;
        while (!tx_finish && n < 60) begin
            tick();
            n++;
        end
        check("simul_finish_seen", tx_finish, 1);
        check("simul_count_before", count, 3);
        tick();
        wr_en   = 1'b1;
        wr_data = 8'h44;
        exp_q.push_back(8'h44);
        tick();
        wr_en = 1'b0;
        check("simul_count_after", count, 3);
        check("simul_tx_start", tx_start, 1);
        check("simul_tx_data", tx_data, 8'h41);
        drain("simul_drain");
        check_rx("simul");
        $display("simul: received=%0d count=%0d", rx_q.size(), count);

        // Pointer wrap: 40 bytes in four bursts of 10.
        clear_logs();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) push_byte(8'h60 + 8'(b * 10 + i));
            wr_en = 1'b0;
            drain($sformatf("wrap_drain%0d", b));
        end
        check("wrap_overflow", overflow, 0);
        check_rx("wrap");
        $display("wrap: received=%0d overflow=%0b", rx_q.size(), overflow);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
